hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline-sequencing controller for the five-stage CPU.
- Decides each cycle whether the F and D pipeline registers hold and whether the E pipeline register is cleared (bubble inserted). Three stall sources: Tuse/Tnew data hazards, mult/div-unit occupancy, and eret-versus-EPC-write conflicts.
- Owns the mult/div busy sequencer (state machine plus latency counter).
- Gives the exception request (Req) priority over every stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rs_D  input  5  D-stage rs index.
- rt_D  input  5  D-stage rt index.
- Tuse_rs_D  input  2  cycles until rs is consumed (3 = unused).
- Tuse_rt_D  input  2  cycles until rt is consumed (3 = unused).
- WriteReg_E  input  5  E-stage destination register.
- Tnew_E  input  2  cycles until the E result is ready.
- WriteReg_M  input  5  M-stage destination register.
- Tnew_M  input  2  cycles until the M result is ready.
- md_use_D  input  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  input  1  E instr launches mult/div.
- md_is_div_E  input  1  the launch is a divide.
- eret_D  input  1  D instr is eret.
- mtc0_epc_E  input  1  E instr is mtc0 to EPC.
- mtc0_epc_M  input  1  M instr is mtc0 to EPC.
- Req  input  1  exception/interrupt flush request from CP0.
- en_F  output  1  PC/F register enable.
- en_D  output  1  D register enable.
- clr_E  output  1  E register bubble clear (clr_ER).
- md_busy  output  1  mult/div unit occupied.
- md_done  output  1  one-cycle pulse when a mult/div completes.

Behaviour:
- Data stall (combinational), rs side: rs_D != 0 AND one of:
  - rs_D == WriteReg_E AND Tuse_rs_D < Tnew_E;
  - rs_D == WriteReg_M AND Tuse_rs_D < Tnew_M.
- Data stall, rt side: same rule with rt_D and Tuse_rt_D.
- Register 0 never stalls.
- md stall = md_use_D AND (md_busy OR md_start_E).
- eret stall = eret_D AND (mtc0_epc_E OR mtc0_epc_M).
- stall = OR of all sources.
- Output rules:
  - en_F = en_D = ~stall.
  - clr_E = stall.
  - If Req = 1: en_F = en_D = 1 and clr_E = 0. Req overrides stall; the pipeline registers apply their own Req flush.
- md FSM states: IDLE, BUSY.
- IDLE → BUSY when md_start_E = 1 AND Req = 0. On that edge:
  - cnt <= DIV_CYCLES if md_is_div_E, else MULT_CYCLES.
  - md_start_E with Req = 1 is ignored (the E instruction is being flushed).
- In BUSY, cnt decrements every cycle.
  - When cnt == 1 at an edge: go to IDLE, cnt <= 0, md_done <= 1 for exactly one cycle.
  - md_start_E while BUSY is ignored (md stall prevents it legitimately).
- Req during BUSY does not abort; the operation runs to completion.
- Timing: start accepted at edge T → md_busy high for exactly N cycles after T. md_done is high in the cycle after the last busy cycle; in that cycle md_busy = 0.
- md_busy and md_done are registered. en_F, en_D and clr_E are combinational, with no added latency.
- Reset (reset = 0, asynchronous, any time, including mid-BUSY):
  - state = IDLE, cnt = 0, md_busy = 0, md_done = 0.
  - The combinational outputs follow their inputs; with md_busy = 0 only data and eret stalls remain.
- Counter never underflows: cnt is only decremented in BUSY, and only while cnt ≥ 1.

Test Plan:
- Load-use hazard: WriteReg_E = 8, Tnew_E = 2, rs_D = 8, Tuse_rs_D = 0 → en_F = 0, en_D = 0, clr_E = 1. Same with rs_D = 0 → no stall.
- Mult latency: md_start_E = 1, md_is_div_E = 0 for one cycle → md_busy high for exactly 5 cycles, then md_done pulses one cycle. md_use_D = 1 throughout → stall in the start cycle plus all 5 busy cycles, released in the md_done cycle.
- Div latency: md_is_div_E = 1 → md_busy high for exactly 10 cycles. A Req pulse at busy cycle 4 does not shorten the busy window.
- Req priority: data stall active with Req = 1 → en_F = 1, en_D = 1, clr_E = 0. md_start_E = 1 with Req = 1 → md_busy stays 0.
- eret conflict: eret_D = 1 with mtc0_epc_M = 1 → stall for 1 cycle. With mtc0_epc_E = 1 → stall persists until the mtc0 leaves M.
- Async reset mid-div: drive reset = 0 at busy cycle 3, between clock edges → md_busy = 0 immediately. After reset release, state is IDLE and the next start yields a full-length busy window.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline-sequencing controller for the five-stage CPU. Each cycle it
//   decides whether the F and D pipeline registers hold (en_F/en_D low) and
//   whether a bubble is inserted into E (clr_E high). There are three stall
//   sources:
//     - Tuse/Tnew data hazards against the E and M stage results,
//     - mult/div unit occupancy,
//     - an eret reading EPC while an mtc0-to-EPC is still in flight.
//   It also owns the mult/div busy sequencer. A pending exception request
//   (Req) overrides every stall.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset (0 = reset)
//   rs_D, rt_D   : D-stage source register indices
//   Tuse_rs_D/rt : cycles until the D source is consumed (3 = unused)
//   WriteReg_E/M : destination register of the E / M instruction
//   Tnew_E/M     : cycles until the E / M result becomes forwardable
//   md_use_D     : D instruction uses the mult/div unit or HI/LO
//   md_start_E   : E instruction launches a mult/div
//   md_is_div_E  : the launch is a divide
//   eret_D       : D instruction is eret
//   mtc0_epc_E/M : E / M instruction writes EPC
//   Req          : exception/interrupt flush request from CP0
//   en_F, en_D   : PC/F and D register enables (combinational)
//   clr_E        : E register bubble clear (combinational)
//   md_busy      : mult/div unit occupied (registered)
//   md_done      : one-cycle completion pulse (registered)
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] WriteReg_E,
    input  logic [1:0] Tnew_E,
    input  logic [4:0] WriteReg_M,
    input  logic [1:0] Tnew_M,
    input  logic       md_use_D,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       eret_D,
    input  logic       mtc0_epc_E,
    input  logic       mtc0_epc_M,
    input  logic       Req,
    output logic       en_F,
    output logic       en_D,
    output logic       clr_E,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // A source register hazards against one producer when the producer
    // writes it and the result arrives later than the consumer needs it.
    // Register 0 is hard-wired and therefore never hazards.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst_e,
        input logic [1:0] tnew_e,
        input logic [4:0] dst_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == dst_e) && (tuse < tnew_e);
        hit_m = (src == dst_m) && (tuse < tnew_m);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    logic             data_stall_s;
    logic             md_stall_s;
    logic             eret_stall_s;
    logic             stall_s;

    // Stall source evaluation.
    always_comb begin
        data_stall_s = src_hazard(rs_D, Tuse_rs_D, WriteReg_E, Tnew_E, WriteReg_M, Tnew_M)
                     | src_hazard(rt_D, Tuse_rt_D, WriteReg_E, Tnew_E, WriteReg_M, Tnew_M);
        // md_start_E is included so a HI/LO reader directly behind a
        // launching mult/div waits even though busy is not yet visible.
        md_stall_s   = md_use_D & (busy_r | md_start_E);
        eret_stall_s = eret_D & (mtc0_epc_E | mtc0_epc_M);
        stall_s      = data_stall_s | md_stall_s | eret_stall_s;
    end

    // Pipeline enables and bubble; Req lets the pipeline registers run so
    // they can apply their own flush.
    always_comb begin
        en_F  = 1'b1;
        en_D  = 1'b1;
        clr_E = 1'b0;
        if (Req) begin
            en_F  = 1'b1;
            en_D  = 1'b1;
            clr_E = 1'b0;
        end else begin
            en_F  = ~stall_s;
            en_D  = ~stall_s;
            clr_E = stall_s;
        end
    end

    // Mult/div sequencer next-state, counter and flag logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            MD_IDLE: begin
                // A launch under Req belongs to a flushed instruction.
                if (md_start_E && !Req) begin
                    state_nxt_s = MD_BUSY;
                    cnt_nxt_s   = md_is_div_E ? DIV_LOAD : MULT_LOAD;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    busy_nxt_s  = 1'b0;
                end
            end
            MD_BUSY: begin
                // Req and further launches do not disturb a running op.
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    busy_nxt_s  = 1'b1;
                end else begin
                    // Unreachable zero count: recover to idle, never wrap.
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    busy_nxt_s  = 1'b0;
                end
            end
            default: begin
                state_nxt_s = MD_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Mult/div sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign md_busy = busy_r;
    assign md_done = done_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, WriteReg_E, WriteReg_M;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
    logic       md_use_D, md_start_E, md_is_div_E, eret_D;
    logic       mtc0_epc_E, mtc0_epc_M, Req;
    logic       en_F, en_D, clr_E, md_busy, md_done;

    int errors = 0;
    int checks = 0;

    // reference model: remaining busy cycles of the mult/div unit
    int exp_left = 0;
    bit exp_done = 1'b0;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .WriteReg_E(WriteReg_E), .Tnew_E(Tnew_E),
        .WriteReg_M(WriteReg_M), .Tnew_M(Tnew_M),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .eret_D(eret_D), .mtc0_epc_E(mtc0_epc_E), .mtc0_epc_M(mtc0_epc_M),
        .Req(Req),
        .en_F(en_F), .en_D(en_D), .clr_E(clr_E),
        .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
        bit e_hit, m_hit;
        e_hit = (r == WriteReg_E) && (int'(tu) < int'(Tnew_E));
        m_hit = (r == WriteReg_M) && (int'(tu) < int'(Tnew_M));
        return (r != 5'd0) && (e_hit || m_hit);
    endfunction

    function automatic bit exp_stall();
        bit s;
        s = hz(rs_D, Tuse_rs_D) || hz(rt_D, Tuse_rt_D);
        s = s || (md_use_D && (exp_left > 0 || md_start_E));
        s = s || (eret_D && (mtc0_epc_E || mtc0_epc_M));
        return s;
    endfunction

    // check combinational outputs shortly after inputs change
    task automatic check_comb();
        bit s;
        #1;
        s = exp_stall();
        chk("en_F",  32'(en_F),  32'(Req ? 1'b1 : !s));
        chk("en_D",  32'(en_D),  32'(Req ? 1'b1 : !s));
        chk("clr_E", 32'(clr_E), 32'(Req ? 1'b0 : s));
    endtask

    // advance one clock: update model at the edge, check registered outputs,
    // then return at the following falling edge ready for new inputs
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            exp_left = 0;
            exp_done = 1'b0;
        end else if (exp_left > 0) begin
            exp_left--;
            exp_done = (exp_left == 0);
        end else begin
            exp_done = 1'b0;
            if (md_start_E && !Req) exp_left = md_is_div_E ? 10 : 5;
        end
        #1;
        chk("md_busy", 32'(md_busy), 32'(exp_left > 0));
        chk("md_done", 32'(md_done), 32'(exp_done));
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs_D = 5'd0; rt_D = 5'd0; WriteReg_E = 5'd0; WriteReg_M = 5'd0;
        Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3; Tnew_E = 2'd0; Tnew_M = 2'd0;
        md_use_D = 1'b0; md_start_E = 1'b0; md_is_div_E = 1'b0; eret_D = 1'b0;
        mtc0_epc_E = 1'b0; mtc0_epc_M = 1'b0; Req = 1'b0;
    endtask

    // launch one op, then count busy cycles (bounded) with an optional Req pulse
    task automatic run_op(input bit is_div, input int req_at, input int n_exp, input string tag);
        int n_busy;
        int saw_done;
        n_busy = 0;
        saw_done = 0;
        for (int i = 0; i < 16; i++) begin
            md_start_E  = (i == 0);
            md_is_div_E = is_div;
            md_use_D    = 1'b1;
            Req         = (i == req_at);
            check_comb();
            tick();
            if (md_busy) n_busy++;
            if (md_done) saw_done++;
        end
        chk({tag, "_busy_len"}, 32'(n_busy), 32'(n_exp));
        chk({tag, "_done_cnt"}, 32'(saw_done), 32'd1);
        clear_inputs();
    endtask

    initial begin
        int n_busy;
        clear_inputs();
        reset = 1'b0;
        #2;
        check_comb();
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();

        // load-use hazard and its register-0 counterpart
        WriteReg_E = 5'd8; Tnew_E = 2'd2; rs_D = 5'd8; Tuse_rs_D = 2'd0;
        check_comb();
        chk("lu_enF", 32'(en_F), 32'd0);
        chk("lu_clr", 32'(clr_E), 32'd1);
        rs_D = 5'd0; WriteReg_E = 5'd0;
        check_comb();
        chk("r0_enF", 32'(en_F), 32'd1);
        clear_inputs();
        tick();

        // mult and div latency (div with a Req pulse mid-operation)
        run_op(1'b0, -1, 5, "mult");
        run_op(1'b1, 4, 10, "div");

        // Req priority over data stall and over a launch
        WriteReg_M = 5'd3; Tnew_M = 2'd1; rt_D = 5'd3; Tuse_rt_D = 2'd0;
        Req = 1'b1; md_start_E = 1'b1;
        check_comb();
        chk("req_enD", 32'(en_D), 32'd1);
        chk("req_clr", 32'(clr_E), 32'd0);
        tick();
        chk("req_nostart", 32'(md_busy), 32'd0);
        clear_inputs();

        // eret conflicts
        eret_D = 1'b1; mtc0_epc_M = 1'b1;
        check_comb();
        chk("eret_m", 32'(en_F), 32'd0);
        tick();
        mtc0_epc_M = 1'b0; mtc0_epc_E = 1'b1;
        check_comb();
        tick();
        mtc0_epc_E = 1'b0; mtc0_epc_M = 1'b1;
        check_comb();
        tick();
        mtc0_epc_M = 1'b0;
        check_comb();
        chk("eret_free", 32'(en_F), 32'd1);
        clear_inputs();

        // asynchronous reset mid-divide
        md_start_E = 1'b1; md_is_div_E = 1'b1;
        check_comb();
        tick();
        clear_inputs();
        tick(); tick();
        #2 reset = 1'b0;
        exp_left = 0; exp_done = 1'b0;
        #1;
        chk("arst_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        run_op(1'b1, -1, 10, "post_rst");

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
            WriteReg_E = 5'($urandom_range(0, 3)); WriteReg_M = 5'($urandom_range(0, 3));
            Tuse_rs_D = 2'($urandom_range(0, 3)); Tuse_rt_D = 2'($urandom_range(0, 3));
            Tnew_E = 2'($urandom_range(0, 3)); Tnew_M = 2'($urandom_range(0, 3));
            md_use_D = 1'($urandom_range(0, 1));
            md_start_E = ($urandom_range(0, 4) == 0);
            md_is_div_E = 1'($urandom_range(0, 1));
            eret_D = ($urandom_range(0, 3) == 0);
            mtc0_epc_E = ($urandom_range(0, 3) == 0);
            mtc0_epc_M = ($urandom_range(0, 3) == 0);
            Req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                exp_left = 0; exp_done = 1'b0;
                #1;
                chk("rnd_arst", 32'(md_busy), 32'd0);
            end else begin
                reset = 1'b1;
            end
            check_comb();
            tick();
        end
        reset = 1'b1;

        // final clean mult window
        clear_inputs();
        for (int i = 0; i < 12; i++) tick();
        n_busy = 0;
        md_start_E = 1'b1;
        check_comb();
        tick();
        md_start_E = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (md_busy) n_busy++;
            tick();
        end
        chk("final_mult_len", 32'(n_busy), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
